// File: rtl/serial_tx_if.sv
// Request/acknowledge handshake between the keyboard control FSM (master)
// and the serial transmitter (slave). s_data is valid and stable while s_req is high.
interface serial_tx_if;
  logic       s_req;
  logic [7:0] s_data;
  logic       s_ack;

  modport master (
    output s_req,
    output s_data,
    input  s_ack
  );

  modport slave (
    input  s_req,
    input  s_data,
    output s_ack
  );
endinterface

// File: rtl/serial_tx.sv
// Serial (UART) transmitter behind a 4-phase req/ack handshake.
// One byte is latched per request and sent as start, 8 data bits LSB first,
// optional parity and 1 or 2 stop bits. s_ack rises only once the last stop
// bit has left the pin, so the handshake doubles as flow control.
module serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,  // >= 2
  parameter int unsigned PARITY       = 0,    // 0 none, 1 odd, 2 even
  parameter int unsigned STOP_BITS    = 1     // 1 or 2
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_tx_if.slave  s_bus,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned     BaudW     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      StopLast  = 3'(STOP_BITS - 1);
  localparam bit              HasParity = (PARITY != 0);
  localparam bit              OddParity = (PARITY == 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop,
    StAck
  } state_e;

  state_e            r_state, w_state_d;
  logic [BaudW-1:0]  r_baud,  w_baud_d;
  logic [2:0]        r_bit,   w_bit_d;
  logic [7:0]        r_shift, w_shift_d;
  logic              r_par,   w_par_d;
  logic              r_tx,    w_tx_d;
  logic              r_ack,   w_ack_d;
  logic              r_busy,  w_busy_d;
  logic              w_bit_end;
  logic              w_in_frame;

  assign w_bit_end  = (r_baud == BaudLast);
  assign w_in_frame = (r_state == StStart) || (r_state == StData) ||
                      (r_state == StPar)   || (r_state == StStop);

  // Next-state, bit timing and registered-output values
  always_comb begin
    w_state_d = r_state;
    w_baud_d  = r_baud;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_par_d   = r_par;
    w_tx_d    = r_tx;
    w_ack_d   = r_ack;

    // Baud counter only runs while a frame is on the wire; it wraps to 0 at
    // every bit boundary, so it is already 0 when the frame ends.
    if (w_in_frame) begin
      w_baud_d = w_bit_end ? '0 : r_baud + 1'b1;
    end

    case (r_state)
      StIdle: begin
        w_tx_d  = 1'b1;
        w_ack_d = 1'b0;
        if (s_bus.s_req) begin
          w_shift_d = s_bus.s_data;
          w_par_d   = OddParity ? ~^s_bus.s_data : ^s_bus.s_data;
          w_baud_d  = '0;
          w_bit_d   = '0;
          w_tx_d    = 1'b0;
          w_state_d = StStart;
        end
      end

      StStart: begin
        if (w_bit_end) begin
          w_tx_d    = r_shift[0];
          w_state_d = StData;
        end
      end

      StData: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            w_bit_d = '0;
            if (HasParity) begin
              w_tx_d    = r_par;
              w_state_d = StPar;
            end else begin
              w_tx_d    = 1'b1;
              w_state_d = StStop;
            end
          end else begin
            w_bit_d   = r_bit + 3'd1;
            w_shift_d = r_shift >> 1;
            w_tx_d    = r_shift[1];
          end
        end
      end

      StPar: begin
        if (w_bit_end) begin
          w_tx_d    = 1'b1;
          w_state_d = StStop;
        end
      end

      StStop: begin
        w_tx_d = 1'b1;
        if (w_bit_end) begin
          if (r_bit == StopLast) begin
            w_bit_d   = '0;
            w_ack_d   = 1'b1;
            w_state_d = StAck;
          end else begin
            w_bit_d = r_bit + 3'd1;
          end
        end
      end

      StAck: begin
        // A request dropped mid-frame lands here with s_req already low,
        // which yields a single-cycle ack pulse.
        w_tx_d = 1'b1;
        if (!s_bus.s_req) begin
          w_ack_d   = 1'b0;
          w_state_d = StIdle;
        end
      end

      default: begin
        w_tx_d    = 1'b1;
        w_ack_d   = 1'b0;
        w_baud_d  = '0;
        w_bit_d   = '0;
        w_state_d = StIdle;
      end
    endcase

    w_busy_d = (w_state_d != StIdle);
  end

  // State and output registers; reset aborts any frame and releases the line high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_par   <= w_par_d;
      r_tx    <= w_tx_d;
      r_ack   <= w_ack_d;
      r_busy  <= w_busy_d;
    end
  end

  assign tx          = r_tx;
  assign busy        = r_busy;
  assign s_bus.s_ack = r_ack;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: four instances cover no parity, even parity, odd parity
// and two stop bits at a short bit time. Expected line levels come from a
// frame model built from the bit-order rules, indexed by cycle within the frame.
module tb_serial_tx;

  logic       clk;
  logic       rst_n;
  logic       r_req  [4];
  logic [7:0] r_data [4];
  logic       w_tx   [4];
  logic       w_ack  [4];
  logic       w_busy [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  serial_tx_if u_if0 ();
  serial_tx_if u_if1 ();
  serial_tx_if u_if2 ();
  serial_tx_if u_if3 ();

  assign u_if0.s_req  = r_req[0];
  assign u_if0.s_data = r_data[0];
  assign w_ack[0]     = u_if0.s_ack;
  assign u_if1.s_req  = r_req[1];
  assign u_if1.s_data = r_data[1];
  assign w_ack[1]     = u_if1.s_ack;
  assign u_if2.s_req  = r_req[2];
  assign u_if2.s_data = r_data[2];
  assign w_ack[2]     = u_if2.s_ack;
  assign u_if3.s_req  = r_req[3];
  assign u_if3.s_data = r_data[3];
  assign w_ack[3]     = u_if3.s_ack;

  serial_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_bus(u_if0), .tx(w_tx[0]), .busy(w_busy[0])
  );
  serial_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_bus(u_if1), .tx(w_tx[1]), .busy(w_busy[1])
  );
  serial_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_bus(u_if2), .tx(w_tx[2]), .busy(w_busy[2])
  );
  serial_tx #(.CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .s_bus(u_if3), .tx(w_tx[3]), .busy(w_busy[3])
  );

  // Per-instance configuration mirrors the parameters above
  function automatic int cpb(input int u);
    return (u == 3) ? 2 : 4;
  endfunction

  function automatic int par_mode(input int u);
    case (u)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stops(input int u);
    return (u == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int u);
    return cpb(u) * (1 + 8 + ((par_mode(u) != 0) ? 1 : 0) + stops(u));
  endfunction

  // Line level in cycle k of a frame carrying byte d
  function automatic logic exp_bit(input int u, input logic [7:0] d, input int k);
    int idx;
    int ones;
    idx = k / cpb(u);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (par_mode(u) != 0 && idx == 9) begin
      ones = $countones(d);
      if (par_mode(u) == 1) return ((ones % 2) == 0);
      return ((ones % 2) == 1);
    end
    return 1'b1;
  endfunction

  // One full handshake as the control FSM drives it; t_start is the cycle tx fell
  task automatic send_frame(input int u, input logic [7:0] d, input bit drop_mid,
                            input bit poke, input int hold, output int t_start);
    int  f;
    bit  started;
    f       = frame_len(u);
    t_start = -1;
    @(negedge clk);
    r_data[u] = d;
    r_req[u]  = 1'b1;
    started   = 1'b0;
    for (int w = 0; w < 4 && !started; w++) begin
      @(negedge clk);
      if (w_tx[u] === 1'b0) started = 1'b1;
    end
    checks++;
    if (!started) begin
      errors++;
      $display("FAIL start u%0d byte %h: tx=%b, required 0 within 4 cycles", u, d, w_tx[u]);
      r_req[u] = 1'b0;
      repeat (f + 4) @(negedge clk);
      return;
    end
    t_start = cyc;
    for (int k = 0; k < f; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (w_tx[u] !== exp_bit(u, d, k)) begin
        errors++;
        $display("FAIL frame_bit u%0d byte %h cycle %0d: tx=%b, required %b",
                 u, d, k, w_tx[u], exp_bit(u, d, k));
      end
      checks++;
      if (w_ack[u] !== 1'b0 || w_busy[u] !== 1'b1) begin
        errors++;
        $display("FAIL frame_status u%0d cycle %0d: ack=%b busy=%b, required ack=0 busy=1",
                 u, k, w_ack[u], w_busy[u]);
      end
      if (k == f / 2) begin
        if (drop_mid) r_req[u] = 1'b0;
        if (poke)     r_data[u] = ~d;
      end
    end
    @(negedge clk);
    checks++;
    if (w_ack[u] !== 1'b1 || w_tx[u] !== 1'b1) begin
      errors++;
      $display("FAIL ack_rise u%0d after %0d cycles: ack=%b tx=%b, required ack=1 tx=1",
               u, f, w_ack[u], w_tx[u]);
    end
    if (!drop_mid) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (w_ack[u] !== 1'b1 || w_busy[u] !== 1'b1 || w_tx[u] !== 1'b1) begin
          errors++;
          $display("FAIL ack_hold u%0d: ack=%b busy=%b tx=%b, required 1 1 1",
                   u, w_ack[u], w_busy[u], w_tx[u]);
        end
      end
      r_req[u] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (w_ack[u] !== 1'b0 || w_busy[u] !== 1'b0 || w_tx[u] !== 1'b1) begin
      errors++;
      $display("FAIL ack_drop u%0d: ack=%b busy=%b tx=%b, required ack=0 busy=0 tx=1",
               u, w_ack[u], w_busy[u], w_tx[u]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int u = 0; u < 4; u++) begin
      r_req[u]  = 1'b0;
      r_data[u] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (w_tx[u] !== 1'b1 || w_ack[u] !== 1'b0 || w_busy[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state u%0d: tx=%b ack=%b busy=%b, required 1 0 0",
                 u, w_tx[u], w_ack[u], w_busy[u]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    r_data[0] = 8'h5A;
    r_req[0]  = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (w_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy: busy=%b, required 1", w_busy[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (w_tx[0] !== 1'b1 || w_ack[0] !== 1'b0 || w_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tx=%b ack=%b busy=%b, required 1 0 0",
               w_tx[0], w_ack[0], w_busy[0]);
    end
    r_req[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (w_tx[0] !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold_tx cycle %0d: tx=%b, required 1", i, w_tx[0]);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cycle %0d: tx=%b busy=%b, required 1 0",
                 i, w_tx[0], w_busy[0]);
      end
    end
  endtask

  task automatic test_single_byte;
    int t;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 2, t);
  endtask

  task automatic test_parity;
    int t;
    send_frame(1, 8'h07, 1'b0, 1'b0, 1, t);
    send_frame(2, 8'h07, 1'b0, 1'b0, 1, t);
    send_frame(1, 8'hC3, 1'b0, 1'b0, 0, t);
    send_frame(2, 8'hC3, 1'b0, 1'b0, 0, t);
  endtask

  task automatic test_back_to_back;
    int t1;
    int t2;
    int gap;
    send_frame(0, 8'h41, 1'b0, 1'b0, 0, t1);
    send_frame(0, 8'h42, 1'b0, 1'b0, 0, t2);
    // tx is high from the end of the last data bit of the first frame
    gap = t2 - (t1 + frame_len(0) - stops(0) * cpb(0));
    checks++;
    if (t1 < 0 || t2 < 0 || gap < cpb(0)) begin
      errors++;
      $display("FAIL b2b_gap: high cycles between frames=%0d, required >= %0d", gap, cpb(0));
    end
  endtask

  task automatic test_violation;
    int t;
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1, t);
    send_frame(0, 8'hC3, 1'b1, 1'b0, 0, t);
    send_frame(1, 8'h96, 1'b1, 1'b1, 0, t);
  endtask

  task automatic test_two_stop;
    int t;
    send_frame(3, 8'hFF, 1'b0, 1'b0, 1, t);
    send_frame(3, 8'h00, 1'b0, 1'b0, 0, t);
  endtask

  task automatic test_random;
    int t;
    for (int i = 0; i < 8; i++) begin
      send_frame($urandom_range(3, 0), 8'($urandom), 1'b0, 1'b0, $urandom_range(3, 0), t);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_violation();
    test_two_stop();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required completion within 1 ms");
    $fatal(1, "timeout");
  end

endmodule
